// File: rtl/sram_pkg.sv
// Shared types and defaults for the pipeline-to-async-SRAM data-memory back end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sram_pkg;

   // Controller FSM: one phase per 16-bit half plus a single ready cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
   localparam int unsigned SRAM_AW_DEF   = 18;
   localparam int unsigned HALF_W        = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one 16-bit SRAM half-access; flags the last held cycle.
// Latency: terminal is combinational from the registered count.
// Backpressure: none; counts while en, clear has priority over en.
//
// Ports: clk, rst (sync active-high), clear (reset count to 0), en (increment),
//        terminal (count == WAIT_CYCLES-1).
module sram_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic terminal
);

   localparam logic [3:0] TERM = 4'(WAIT_CYCLES - 1);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign terminal = (cnt_q == TERM);

endmodule

// File: rtl/sram_controller.sv
// 32-bit MEM-stage load/store mapped onto two 16-bit async SRAM accesses with wait states.
// Latency: 1 + 2*WAIT_CYCLES stall cycles, ready in the DONE cycle after that.
// Backpressure: ready is low while a request is pending and not yet in DONE; pipeline freezes.
//
// Ports: clk, rst (sync active-high); wr_en/rd_en/address/write_data from MEM stage;
//        read_data (registered load result), ready (combinational stall);
//        sram_addr/sram_dq_out/sram_dq_oe/sram_we_n to the SRAM, sram_dq_in from it.
module sram_controller
   import sram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [HALF_W-1:0]  sram_dq_out,
   input  logic [HALF_W-1:0]  sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int unsigned WIDX_W = SRAM_AW - 1;

   state_e              state_q, state_d;
   logic                is_wr_q, is_wr_d;
   logic [WIDX_W-1:0]   widx_q, widx_d;
   logic [HALF_W-1:0]   wdata_hi_q, wdata_hi_d;
   logic [HALF_W-1:0]   rdata_lo_q, rdata_lo_d;
   logic [31:0]         read_data_q, read_data_d;
   logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
   logic [HALF_W-1:0]   dq_out_q, dq_out_d;
   logic                dq_oe_q, dq_oe_d;
   logic                we_n_q, we_n_d;

   logic                req;
   logic [31:0]         offset;
   logic [WIDX_W-1:0]   widx_in;
   logic                cnt_clear;
   logic                cnt_en;
   logic                cnt_term;

   assign req     = wr_en | rd_en;
   assign offset  = address - BASE_ADDR;
   // Word index is offset>>2; only the bits that fit beside the half select are kept.
   assign widx_in = offset[SRAM_AW:2];

   logic unused_offset_bits;
   assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

   sram_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .en       (cnt_en),
      .terminal (cnt_term)
   );

   // Pin registers are loaded with the values for the state being entered,
   // so the SRAM sees stable address/data/strobe for the whole phase.
   always_comb begin
      state_d     = state_q;
      is_wr_d     = is_wr_q;
      widx_d      = widx_q;
      wdata_hi_d  = wdata_hi_q;
      rdata_lo_d  = rdata_lo_q;
      read_data_d = read_data_q;
      sram_addr_d = sram_addr_q;
      dq_out_d    = dq_out_q;
      dq_oe_d     = dq_oe_q;
      we_n_d      = we_n_q;
      cnt_clear   = 1'b0;
      cnt_en      = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_clear = 1'b1;
            if (req) begin
               // Write wins when both enables are up.
               is_wr_d     = wr_en;
               widx_d      = widx_in;
               wdata_hi_d  = write_data[31:16];
               sram_addr_d = {widx_in, 1'b0};
               if (wr_en) begin
                  dq_out_d = write_data[15:0];
               end
               dq_oe_d     = wr_en;
               we_n_d      = ~wr_en;
               state_d     = LOW;
            end
         end
         LOW: begin
            if (cnt_term) begin
               cnt_clear   = 1'b1;
               state_d     = HIGH;
               sram_addr_d = {widx_q, 1'b1};
               if (is_wr_q) begin
                  dq_out_d = wdata_hi_q;
               end else begin
                  rdata_lo_d = sram_dq_in;
               end
               // Strobe and OE stay as they are: a write keeps we_n low across the address change.
            end else begin
               cnt_en = 1'b1;
            end
         end
         HIGH: begin
            if (cnt_term) begin
               cnt_clear = 1'b1;
               state_d   = DONE;
               if (!is_wr_q) begin
                  read_data_d = {sram_dq_in, rdata_lo_q};
               end
               dq_oe_d = 1'b0;
               we_n_d  = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            cnt_clear = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         is_wr_q     <= 1'b0;
         widx_q      <= '0;
         wdata_hi_q  <= '0;
         rdata_lo_q  <= '0;
         read_data_q <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         is_wr_q     <= is_wr_d;
         widx_q      <= widx_d;
         wdata_hi_q  <= wdata_hi_d;
         rdata_lo_q  <= rdata_lo_d;
         read_data_q <= read_data_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         we_n_q      <= we_n_d;
      end
   end

   // A dropped request releases the pipeline at once; the latched access still runs to DONE.
   assign ready       = ~req | (state_q == DONE);
   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: default instance (WAIT_CYCLES=2) and a WAIT_CYCLES=1 rebuild,
// each with its own behavioural 256K x 16 async SRAM.
// Expected per-access results are queued at issue and compared when ready rises.
module tb_sram_controller;
   import sram_pkg::*;

   typedef struct {
      int          stall;
      int          we_low;
      logic [31:0] rdata;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        wr_en_v      [2];
   logic        rd_en_v      [2];
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data_v  [2];
   logic        ready_v      [2];
   logic [17:0] sram_addr_v  [2];
   logic [15:0] sram_dq_out_v[2];
   logic [15:0] sram_dq_in_v [2];
   logic        sram_dq_oe_v [2];
   logic        sram_we_n_v  [2];

   logic [15:0] mem    [2][262144];
   logic [15:0] shadow [2][262144];
   logic [31:0] last_rd [2];
   exp_t        sb [$];

   int n_checks = 0;
   int n_pass   = 0;

   sram_controller u0 (
      .clk (clk), .rst (rst), .wr_en (wr_en_v[0]), .rd_en (rd_en_v[0]),
      .address (address), .write_data (write_data), .read_data (read_data_v[0]),
      .ready (ready_v[0]), .sram_addr (sram_addr_v[0]), .sram_dq_out (sram_dq_out_v[0]),
      .sram_dq_in (sram_dq_in_v[0]), .sram_dq_oe (sram_dq_oe_v[0]), .sram_we_n (sram_we_n_v[0])
   );

   sram_controller #(.WAIT_CYCLES (1)) u1 (
      .clk (clk), .rst (rst), .wr_en (wr_en_v[1]), .rd_en (rd_en_v[1]),
      .address (address), .write_data (write_data), .read_data (read_data_v[1]),
      .ready (ready_v[1]), .sram_addr (sram_addr_v[1]), .sram_dq_out (sram_dq_out_v[1]),
      .sram_dq_in (sram_dq_in_v[1]), .sram_dq_oe (sram_dq_oe_v[1]), .sram_we_n (sram_we_n_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Async SRAM: reads are combinational, writes land while we_n is low.
   assign sram_dq_in_v[0] = mem[0][sram_addr_v[0]];
   assign sram_dq_in_v[1] = mem[1][sram_addr_v[1]];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!sram_we_n_v[i] && sram_dq_oe_v[i]) begin
            mem[i][sram_addr_v[i]] = sram_dq_out_v[i];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int hw_of(input logic [31:0] addr);
      logic [31:0] w;
      w = (addr - 32'd1024) >> 2;
      return int'(w[16:0]) * 2;
   endfunction

   task automatic model_write(input int sel, input logic [31:0] addr, input logic [31:0] wd);
      shadow[sel][hw_of(addr)]     = wd[15:0];
      shadow[sel][hw_of(addr) + 1] = wd[31:16];
   endtask

   function automatic logic [31:0] model_read(input int sel, input logic [31:0] addr);
      return {shadow[sel][hw_of(addr) + 1], shadow[sel][hw_of(addr)]};
   endfunction

   function automatic logic [31:0] fsm_state(input int sel);
      return (sel == 0) ? 32'(u0.state_q) : 32'(u1.state_q);
   endfunction

   // Issue one access, hold it until ready, compare against the queued expectation.
   task automatic do_access(input int sel, input logic wr, input logic rd,
                            input logic [31:0] addr, input logic [31:0] wd);
      exp_t e;
      int   w;
      int   stall;
      int   we_low;
      bit   done;
      w = (sel == 0) ? 2 : 1;
      if (wr) model_write(sel, addr, wd);
      else if (rd) last_rd[sel] = model_read(sel, addr);
      e.stall  = 1 + 2 * w;
      e.we_low = wr ? 2 * w : 0;
      e.rdata  = last_rd[sel];
      sb.push_back(e);

      @(negedge clk);
      check("idle_at_req", fsm_state(sel), 32'(IDLE));
      address     = addr;
      write_data  = wd;
      wr_en_v[sel] = wr;
      rd_en_v[sel] = rd;
      stall  = 0;
      we_low = 0;
      done   = 0;
      for (int c = 0; c < 64 && !done; c++) begin
         #1;
         if (ready_v[sel]) begin
            done = 1;
         end else begin
            stall++;
            @(negedge clk);
            if (!sram_we_n_v[sel]) we_low++;
         end
      end
      e = sb.pop_front();
      check("ready_timeout", 32'(done), 32'd1);
      check("stall_cycles", stall, e.stall);
      check("we_n_low_cycles", we_low, e.we_low);
      check("read_data", read_data_v[sel], e.rdata);
      @(posedge clk);
      #1;
      wr_en_v[sel] = 1'b0;
      rd_en_v[sel] = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      wr_en_v[0] = 1'b0; wr_en_v[1] = 1'b0;
      rd_en_v[0] = 1'b0; rd_en_v[1] = 1'b0;
      address    = '0;
      write_data = '0;
      last_rd[0] = '0;  last_rd[1] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_read_data", read_data_v[0], 32'h0);
      check("rst_ready", 32'(ready_v[0]), 32'd1);
      check("rst_we_n", 32'(sram_we_n_v[0]), 32'd1);
      check("rst_oe", 32'(sram_dq_oe_v[0]), 32'd0);
      check("rst_addr", 32'(sram_addr_v[0]), 32'h0);
      check("rst_dq_out", 32'(sram_dq_out_v[0]), 32'h0);
      check("rst_state", fsm_state(0), 32'(IDLE));
      check("rst_we_n_w1", 32'(sram_we_n_v[1]), 32'd1);
      rst = 1'b0;

      // Store, load, load unchanged by store, write-wins
      do_access(0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
      check("mem4", 32'(mem[0][4]), 32'h0000BEEF);
      check("mem5", 32'(mem[0][5]), 32'h0000DEAD);
      do_access(0, 1'b0, 1'b1, 32'd1032, 32'h0);
      do_access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
      check("mem0", 32'(mem[0][0]), 32'h00005678);
      check("mem1", 32'(mem[0][1]), 32'h00001234);
      do_access(0, 1'b0, 1'b1, 32'd1024, 32'h0);

      // Request dropped in its third cycle: ready rises at once, access still completes.
      model_write(0, 32'd1048, 32'hCAFEF00D);
      @(negedge clk);
      address      = 32'd1048;
      write_data   = 32'hCAFEF00D;
      wr_en_v[0]   = 1'b1;
      #1 check("drop_stall", 32'(ready_v[0]), 32'd0);
      repeat (2) @(negedge clk);
      wr_en_v[0]   = 1'b0;
      write_data   = 32'h0;
      #1 check("drop_ready", 32'(ready_v[0]), 32'd1);
      repeat (3) @(negedge clk);
      check("drop_done", fsm_state(0), 32'(DONE));
      check("drop_mem12", 32'(mem[0][12]), 32'h0000F00D);
      check("drop_mem13", 32'(mem[0][13]), 32'h0000CAFE);
      do_access(0, 1'b0, 1'b1, 32'd1048, 32'h0);

      // WAIT_CYCLES=1 rebuild
      do_access(1, 1'b1, 1'b0, 32'd1040, 32'h0BADCAFE);
      check("w1_mem8", 32'(mem[1][8]), 32'h0000CAFE);
      do_access(1, 1'b0, 1'b1, 32'd1040, 32'h0);

      // Reset during the HIGH phase of a write
      @(negedge clk);
      address    = 32'd1056;
      write_data = 32'hAABBCCDD;
      wr_en_v[0] = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_high_state", fsm_state(0), 32'(HIGH));
      rst        = 1'b1;
      wr_en_v[0] = 1'b0;
      @(negedge clk);
      check("mid_rst_read_data", read_data_v[0], 32'h0);
      check("mid_rst_addr", 32'(sram_addr_v[0]), 32'h0);
      check("mid_rst_dq_out", 32'(sram_dq_out_v[0]), 32'h0);
      check("mid_rst_oe", 32'(sram_dq_oe_v[0]), 32'd0);
      check("mid_rst_we_n", 32'(sram_we_n_v[0]), 32'd1);
      check("mid_rst_state", fsm_state(0), 32'(IDLE));
      check("mid_rst_ready", 32'(ready_v[0]), 32'd1);
      rst        = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;

      // Loads after reset; SRAM contents survive
      do_access(0, 1'b0, 1'b1, 32'd1032, 32'h0);
      do_access(1, 1'b0, 1'b1, 32'd1040, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the summary, expected completion");
      $fatal(1);
   end

endmodule
